// File: rtl/draw_sequencer.sv
// draw_sequencer: command FIFO plus edge sequencer
// that serialises triangles and lines onto one line engine.
module draw_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int COORD_W    = 8
) (
  input  logic               ACLK,
  input  logic               RST,
  input  logic               CMD_VALID,
  output logic               CMD_READY,
  input  logic               CMD_MODE,
  input  logic [COORD_W-1:0] CMD_X0,
  input  logic [COORD_W-1:0] CMD_Y0,
  input  logic [COORD_W-1:0] CMD_X1,
  input  logic [COORD_W-1:0] CMD_Y1,
  input  logic [COORD_W-1:0] CMD_X2,
  input  logic [COORD_W-1:0] CMD_Y2,
  input  logic               ABORT,
  output logic               LINE_START,
  output logic [COORD_W-1:0] LINE_XA,
  output logic [COORD_W-1:0] LINE_YA,
  output logic [COORD_W-1:0] LINE_XB,
  output logic [COORD_W-1:0] LINE_YB,
  input  logic               LINE_DONE,
  output logic [1:0]         EDGE_IDX,
  output logic               BUSY,
  output logic [15:0]        CMD_COUNT
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic               mode;
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic [COORD_W-1:0] x2;
    logic [COORD_W-1:0] y2;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_NEXT
  } state_t;

  cmd_t           r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  cmd_t           r_cmd;
  state_t         r_state;
  logic [1:0]     r_edge;
  logic           r_busy;
  logic [15:0]    r_cmd_count;

  cmd_t           w_in;
  logic           w_full;
  logic           w_empty;
  logic           w_push;
  logic           w_pop;
  logic [CW-1:0]  w_count_nxt;
  state_t         w_state_nxt;
  logic [1:0]     w_edge_nxt;
  logic           w_cnt_inc;

  assign w_in = '{
    mode: CMD_MODE,
    x0:   CMD_X0,
    y0:   CMD_Y0,
    x1:   CMD_X1,
    y1:   CMD_Y1,
    x2:   CMD_X2,
    y2:   CMD_Y2
  };

  // READY depends only on registered count so a full FIFO
  // never accepts, even when a pop happens in the same cycle.
  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign CMD_READY = !RST && !w_full;
  assign w_push    = CMD_VALID && CMD_READY && !ABORT;
  assign w_pop     = (r_state == S_IDLE) && !w_empty && !ABORT;

  always_comb begin
    w_count_nxt = r_count;
    if (ABORT) begin
      w_count_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_in;
    end
  end

  always_ff @(posedge ACLK) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (ABORT) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_edge_nxt  = r_edge;
    w_cnt_inc   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = S_START;
          w_edge_nxt  = 2'd0;
        end
      end
      S_START: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (LINE_DONE) w_state_nxt = S_NEXT;
      end
      S_NEXT: begin
        if (!r_cmd.mode && (r_edge < 2'd2)) begin
          w_edge_nxt  = r_edge + 2'd1;
          w_state_nxt = S_START;
        end else begin
          w_cnt_inc   = 1'b1;
          w_edge_nxt  = 2'd0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (ABORT) begin
      w_state_nxt = S_IDLE;
      w_edge_nxt  = 2'd0;
      w_cnt_inc   = 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_edge      <= 2'd0;
      r_cmd       <= '0;
      r_busy      <= 1'b0;
      r_cmd_count <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_edge  <= w_edge_nxt;
      r_busy  <= (w_state_nxt != S_IDLE) ||
                 (w_count_nxt != '0);
      if (w_pop)     r_cmd       <= r_mem[r_rd_ptr];
      if (w_cnt_inc) r_cmd_count <= r_cmd_count + 16'd1;
    end
  end

  // Endpoints follow the edge index; both are frozen
  // from START through WAIT, so the engine sees them stable.
  always_comb begin
    LINE_XA = r_cmd.x2;
    LINE_YA = r_cmd.y2;
    LINE_XB = r_cmd.x0;
    LINE_YB = r_cmd.y0;
    unique case (r_edge)
      2'd0: begin
        LINE_XA = r_cmd.x0;
        LINE_YA = r_cmd.y0;
        LINE_XB = r_cmd.x1;
        LINE_YB = r_cmd.y1;
      end
      2'd1: begin
        LINE_XA = r_cmd.x1;
        LINE_YA = r_cmd.y1;
        LINE_XB = r_cmd.x2;
        LINE_YB = r_cmd.y2;
      end
      default: begin
        LINE_XA = r_cmd.x2;
        LINE_YA = r_cmd.y2;
        LINE_XB = r_cmd.x0;
        LINE_YB = r_cmd.y0;
      end
    endcase
  end

  assign LINE_START = (r_state == S_START) && !ABORT && !RST;
  assign EDGE_IDX   = r_edge;
  assign BUSY       = r_busy;
  assign CMD_COUNT  = r_cmd_count;

endmodule

// File: tb/tb_draw_sequencer.sv
// tb_draw_sequencer: directed vectors for the
// draw command sequencer.
module tb_draw_sequencer;

  logic        ACLK;
  logic        RST;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic        CMD_MODE;
  logic [7:0]  CMD_X0, CMD_Y0, CMD_X1, CMD_Y1, CMD_X2, CMD_Y2;
  logic        ABORT;
  logic        LINE_START;
  logic [7:0]  LINE_XA, LINE_YA, LINE_XB, LINE_YB;
  logic        LINE_DONE;
  logic [1:0]  EDGE_IDX;
  logic        BUSY;
  logic [15:0] CMD_COUNT;

  int n_chk;
  int n_pass;

  draw_sequencer #(
    .FIFO_DEPTH(4),
    .COORD_W   (8)
  ) dut (
    .ACLK      (ACLK),
    .RST       (RST),
    .CMD_VALID (CMD_VALID),
    .CMD_READY (CMD_READY),
    .CMD_MODE  (CMD_MODE),
    .CMD_X0    (CMD_X0),
    .CMD_Y0    (CMD_Y0),
    .CMD_X1    (CMD_X1),
    .CMD_Y1    (CMD_Y1),
    .CMD_X2    (CMD_X2),
    .CMD_Y2    (CMD_Y2),
    .ABORT     (ABORT),
    .LINE_START(LINE_START),
    .LINE_XA   (LINE_XA),
    .LINE_YA   (LINE_YA),
    .LINE_XB   (LINE_XB),
    .LINE_YB   (LINE_YB),
    .LINE_DONE (LINE_DONE),
    .EDGE_IDX  (EDGE_IDX),
    .BUSY      (BUSY),
    .CMD_COUNT (CMD_COUNT)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag,
                     input int unsigned got,
                     input int unsigned want);
    n_chk++;
    if (got == want) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic set_cmd(input logic m,
                         input logic [7:0] x0, y0,
                         input logic [7:0] x1, y1,
                         input logic [7:0] x2, y2);
    CMD_MODE = m;
    CMD_X0 = x0; CMD_Y0 = y0;
    CMD_X1 = x1; CMD_Y1 = y1;
    CMD_X2 = x2; CMD_Y2 = y2;
  endtask

  task automatic expect_edge(input string tag,
                             input int xa, ya, xb, yb, idx);
    chk({tag, ".start"}, LINE_START, 1);
    chk({tag, ".xa"}, LINE_XA, xa);
    chk({tag, ".ya"}, LINE_YA, ya);
    chk({tag, ".xb"}, LINE_XB, xb);
    chk({tag, ".yb"}, LINE_YB, yb);
    chk({tag, ".idx"}, EDGE_IDX, idx);
  endtask

  // From a START cycle: move into WAIT, pulse done, land in NEXT
  task automatic finish_edge(input string tag);
    step();
    chk({tag, ".pulse"}, LINE_START, 0);
    LINE_DONE = 1'b1;
    step();
    LINE_DONE = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (!LINE_START && n < 12) begin
      step();
      n++;
    end
    chk({tag, ".seen"}, LINE_START, 1);
  endtask

  task automatic no_start(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (LINE_START) seen++;
    end
    chk({tag, ".nostart"}, seen, 0);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    RST = 1'b1;
    CMD_VALID = 1'b0;
    ABORT = 1'b0;
    LINE_DONE = 1'b0;
    set_cmd(0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("rst.ready", CMD_READY, 0);
    chk("rst.start", LINE_START, 0);
    chk("rst.busy", BUSY, 0);
    chk("rst.count", CMD_COUNT, 0);
    chk("rst.idx", EDGE_IDX, 0);
    chk("rst.xa", LINE_XA, 0);
    RST = 1'b0;
    #1;
    chk("rst.ready_rel", CMD_READY, 1);

    // 1: triangle through all three edges
    set_cmd(0, 10, 10, 50, 10, 30, 40);
    CMD_VALID = 1'b1;
    step();
    CMD_VALID = 1'b0;
    chk("t1.lat1", LINE_START, 0);
    chk("t1.busy", BUSY, 1);
    step();
    expect_edge("t1.e0", 10, 10, 50, 10, 0);
    finish_edge("t1.e0");
    chk("t1.next", LINE_START, 0);
    step();
    expect_edge("t1.e1", 50, 10, 30, 40, 1);
    finish_edge("t1.e1");
    step();
    expect_edge("t1.e2", 30, 40, 10, 10, 2);
    finish_edge("t1.e2");
    chk("t1.cnt_pre", CMD_COUNT, 0);
    step();
    chk("t1.cnt", CMD_COUNT, 1);
    chk("t1.idle", BUSY, 0);

    // 2: line mode runs edge 0 only
    set_cmd(1, 0, 0, 255, 255, 7, 7);
    CMD_VALID = 1'b1;
    step();
    CMD_VALID = 1'b0;
    step();
    expect_edge("t2.e0", 0, 0, 255, 255, 0);
    finish_edge("t2.e0");
    step();
    chk("t2.cnt", CMD_COUNT, 2);
    chk("t2.idle", BUSY, 0);
    no_start("t2", 6);

    // 3: five pushes, engine stalled, FIFO fills
    for (int k = 1; k <= 5; k++) begin
      chk("t3.ready", CMD_READY, 1);
      set_cmd(1, 8'(k), 8'(k + 1), 8'(k + 2), 8'(k + 3), 0, 0);
      CMD_VALID = 1'b1;
      step();
      if (k == 2) begin
        chk("t3.first_start", LINE_START, 1);
        chk("t3.first_xa", LINE_XA, 1);
      end
    end
    chk("t3.full", CMD_READY, 0);
    set_cmd(1, 99, 99, 99, 99, 0, 0);
    step();
    step();
    CMD_VALID = 1'b0;
    chk("t3.still_full", CMD_READY, 0);
    chk("t3.hold_xa", LINE_XA, 1);
    LINE_DONE = 1'b1;
    step();
    LINE_DONE = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      wait_start("t3.c");
      chk("t3.xa", LINE_XA, k);
      chk("t3.ya", LINE_YA, k + 1);
      chk("t3.xb", LINE_XB, k + 2);
      chk("t3.yb", LINE_YB, k + 3);
      finish_edge("t3.c");
    end
    step();
    chk("t3.cnt", CMD_COUNT, 7);
    chk("t3.idle", BUSY, 0);
    no_start("t3.sixth", 6);

    // 4: LINE_DONE outside WAIT is ignored
    LINE_DONE = 1'b1;
    step();
    step();
    chk("t4.idle_busy", BUSY, 0);
    chk("t4.idle_cnt", CMD_COUNT, 7);
    set_cmd(0, 1, 2, 3, 4, 5, 6);
    CMD_VALID = 1'b1;
    step();
    CMD_VALID = 1'b0;
    step();
    expect_edge("t4.e0", 1, 2, 3, 4, 0);
    LINE_DONE = 1'b0;
    step();
    step();
    step();
    chk("t4.hold_idx", EDGE_IDX, 0);
    chk("t4.hold_xa", LINE_XA, 1);
    chk("t4.hold_start", LINE_START, 0);
    LINE_DONE = 1'b1;
    step();
    LINE_DONE = 1'b0;
    chk("t4.m1", LINE_START, 0);
    step();
    expect_edge("t4.e1", 3, 4, 5, 6, 1);

    // 5: ABORT in edge 1 with two queued entries
    set_cmd(1, 40, 41, 42, 43, 0, 0);
    CMD_VALID = 1'b1;
    step();
    set_cmd(1, 50, 51, 52, 53, 0, 0);
    step();
    CMD_VALID = 1'b0;
    chk("t5.busy_pre", BUSY, 1);
    ABORT = 1'b1;
    step();
    ABORT = 1'b0;
    chk("t5.busy", BUSY, 0);
    chk("t5.ready", CMD_READY, 1);
    chk("t5.idx", EDGE_IDX, 0);
    chk("t5.cnt", CMD_COUNT, 7);
    no_start("t5", 8);
    chk("t5.cnt_after", CMD_COUNT, 7);

    // 6: reset mid-WAIT with a command presented
    set_cmd(1, 9, 9, 20, 20, 0, 0);
    CMD_VALID = 1'b1;
    step();
    CMD_VALID = 1'b0;
    step();
    chk("t6.start", LINE_START, 1);
    step();
    RST = 1'b1;
    set_cmd(1, 77, 77, 78, 78, 0, 0);
    CMD_VALID = 1'b1;
    #1;
    chk("t6.ready_rst", CMD_READY, 0);
    step();
    chk("t6.busy", BUSY, 0);
    chk("t6.cnt", CMD_COUNT, 0);
    chk("t6.xa", LINE_XA, 0);
    chk("t6.xb", LINE_XB, 0);
    chk("t6.idx", EDGE_IDX, 0);
    chk("t6.start0", LINE_START, 0);
    CMD_VALID = 1'b0;
    RST = 1'b0;
    step();
    chk("t6.nopush", BUSY, 0);
    no_start("t6", 5);

    // 6b: completion counter wraps
    force dut.r_cmd_count = 16'hFFFF;
    step();
    release dut.r_cmd_count;
    step();
    chk("t6.preset", CMD_COUNT, 65535);
    set_cmd(1, 3, 3, 4, 4, 0, 0);
    CMD_VALID = 1'b1;
    step();
    CMD_VALID = 1'b0;
    wait_start("t6.w");
    finish_edge("t6.w");
    step();
    chk("t6.wrap", CMD_COUNT, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
